seq_scan_ctrl: RTL

SEQ_SCAN_CTRL -- requirements
Module: seq_scan_ctrl

---
 rtl/seq_scan_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl
// Serial word scanner. Accepts a W-bit word on a valid/ready handshake,
// shifts it out MSB first through an overlapping Mealy detector for the
// pattern 1010, and reports the per-word match count plus a saturating
// running total.
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : asynchronous, active-high reset
//   in_valid   : requester offers a word
//   in_data    : W-bit word to scan, MSB first
//   clear_hist : taken with the word; 1 = start the detector from A
//   in_ready   : controller is idle and can take a word
//   x_out      : serial bit presented to the detector (0 outside SHIFT)
//   busy       : scan or report in progress
//   done       : one-cycle pulse, match_cnt valid
//   match_cnt  : 1010 matches found in the last scanned word
//   total_cnt  : saturating count of all matches since reset
module seq_scan_ctrl #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          clear_hist,
    output logic          in_ready,
    output logic          x_out,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] match_cnt,
    output logic [15:0]   total_cnt
);

    localparam int BW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_t;
    typedef enum logic [1:0] {DET_A, DET_B, DET_C, DET_D} det_t;

    state_t          state_q, state_d;
    det_t            det_q, det_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [BW-1:0]   bitcnt_q, bitcnt_d;
    logic [CW-1:0]   match_q, match_d;
    logic [15:0]     total_q, total_d;
    logic            xBit;
    logic            match;

    // State register; reset aborts any word in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            det_q    <= DET_A;
            shift_q  <= '0;
            bitcnt_q <= '0;
            match_q  <= '0;
            total_q  <= '0;
        end else begin
            state_q  <= state_d;
            det_q    <= det_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            match_q  <= match_d;
            total_q  <= total_d;
        end
    end

    // Serial bit and detector match are only meaningful while shifting.
    always_comb begin
        xBit  = (state_q == SHIFT) ? shift_q[W-1] : 1'b0;
        match = (state_q == SHIFT) && (det_q == DET_D) && !xBit;
    end

    // Next-state logic for controller, detector and counters.
    always_comb begin
        state_d  = state_q;
        det_d    = det_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        match_d  = match_q;
        total_d  = total_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d  = in_data;
                    bitcnt_d = BW'(W - 1);
                    match_d  = '0;
                    state_d  = SHIFT;
                    // Without clear_hist the detector keeps its state so a
                    // pattern straddling two words is credited to the later one.
                    if (clear_hist) begin
                        det_d = DET_A;
                    end
                end
            end
            SHIFT: begin
                unique case (det_q)
                    DET_A: det_d = xBit ? DET_B : DET_A;
                    DET_B: det_d = xBit ? DET_B : DET_C;
                    DET_C: det_d = xBit ? DET_D : DET_A;
                    DET_D: det_d = xBit ? DET_B : DET_C;
                endcase
                shift_d  = {shift_q[W-2:0], 1'b0};
                bitcnt_d = bitcnt_q - BW'(1);
                if (match) begin
                    match_d = match_q + CW'(1);
                    if (total_q != 16'hFFFF) begin
                        total_d = total_q + 16'd1;
                    end
                end
                if (bitcnt_q == '0) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        done      = (state_q == REPORT);
        x_out     = xBit;
        match_cnt = match_q;
        total_cnt = total_q;
    end

endmodule
